// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: two-port round-robin read sequencer for the shared
// flash Avalon-MM read master, with a per-transfer timeout abort.
`timescale 1ns/1ps
module flash_read_arbiter #(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_data,
  output logic              req0_err,
  input  logic              req1,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_data,
  output logic              req1_err,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic              flash_readdatavalid,
  input  logic [DATA_W-1:0] flash_readdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;

  logic grant;
  logic expire;
  logic fin;
  logic tmo;
  logic cap;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    data0_d = data0_q;
    data1_d = data1_q;
    fin     = 1'b0;
    tmo     = 1'b0;
    cap     = 1'b0;
    expire  = (cnt_q == CNT_LAST);
    // a lone request wins; a tie goes to the port not served last
    grant   = req1;
    if (req0 && req1) begin
      grant = ~last_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_ISSUE;
          owner_d = grant;
          addr_d  = grant ? req1_addr : req0_addr;
          rd_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (expire) begin
          rd_d = 1'b0;
          fin  = 1'b1;
          tmo  = 1'b1;
        end else if (!flash_waitrequest) begin
          rd_d    = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // data beats an expiring counter on the same edge
        if (flash_readdatavalid) begin
          fin = 1'b1;
          cap = 1'b1;
        end else if (expire) begin
          fin = 1'b1;
          tmo = 1'b1;
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fin) begin
      state_d = S_DONE;
    end
    if (cap && !owner_q) begin
      data0_d = flash_readdata;
    end
    if (cap && owner_q) begin
      data1_d = flash_readdata;
    end

    done0_d = fin && !owner_q;
    done1_d = fin && owner_q;
    err0_d  = tmo && !owner_q;
    err1_d  = tmo && owner_q;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  assign flash_read    = rd_q;
  assign flash_address = addr_q;
  assign busy          = busy_q;
  assign owner         = owner_q;
  assign req0_done     = done0_q;
  assign req1_done     = done1_q;
  assign req0_err      = err0_q;
  assign req1_err      = err1_q;
  assign req0_data     = data0_q;
  assign req1_data     = data1_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with literal latency/data expectations.
`timescale 1ns/1ps
module tb_flash_read_arbiter;

  localparam int AW = 23;
  localparam int DW = 16;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic          req0_done, req1_done, req0_err, req1_err;
  logic [DW-1:0] req0_data, req1_data;
  logic          flash_read, flash_waitrequest = 1'b0;
  logic          flash_readdatavalid = 1'b0;
  logic [AW-1:0] flash_address;
  logic [DW-1:0] flash_readdata = '0;
  logic          busy, owner;

  always #10 clk = ~clk;

  flash_read_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req0_addr(req0_addr), .req0_done(req0_done),
    .req0_data(req0_data), .req0_err(req0_err),
    .req1(req1), .req1_addr(req1_addr), .req1_done(req1_done),
    .req1_data(req1_data), .req1_err(req1_err),
    .flash_read(flash_read), .flash_address(flash_address),
    .flash_waitrequest(flash_waitrequest),
    .flash_readdatavalid(flash_readdatavalid),
    .flash_readdata(flash_readdata),
    .busy(busy), .owner(owner)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  // expected outputs, derived per transfer from elapsed cycles since grant
  logic          e_read, e_busy, e_owner;
  logic [AW-1:0] e_addr;
  logic          e_done0, e_done1, e_err0, e_err1;
  logic [DW-1:0] e_data0, e_data1;
  bit            m_act, m_fin, m_acc, m_last;
  int            m_t;

  int  cyc = 0, g_cyc = 0, rd_cnt = 0, d_cyc = 0, n_done = 0;
  bit  d_port, d_err, p_busy;
  int  dq_port[$];
  int  dq_cyc[$];

  task automatic m_finish(input bit err);
    e_read = 1'b0;
    m_act  = 1'b0;
    m_fin  = 1'b1;
    if (e_owner) begin e_done1 = 1'b1; e_err1 = err; end
    else         begin e_done0 = 1'b1; e_err0 = err; end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_act = 0; m_fin = 0; m_acc = 0; m_last = 1; m_t = 0;
      e_read = 0; e_busy = 0; e_owner = 0; e_addr = '0;
      e_done0 = 0; e_done1 = 0; e_err0 = 0; e_err1 = 0;
      e_data0 = '0; e_data1 = '0;
    end else if (m_fin) begin
      m_fin = 0; e_busy = 0; m_last = e_owner;
      e_done0 = 0; e_done1 = 0; e_err0 = 0; e_err1 = 0;
    end else if (m_act) begin
      m_t++;
      if (m_acc && flash_readdatavalid) begin
        if (e_owner) e_data1 = flash_readdata;
        else         e_data0 = flash_readdata;
        m_finish(1'b0);
      end else if (m_t == T) begin
        m_finish(1'b1);
      end else if (!m_acc && !flash_waitrequest) begin
        m_acc  = 1;
        e_read = 0;
      end
    end else if (req0 || req1) begin
      e_owner = (req0 && req1) ? !m_last : req1;
      e_addr  = e_owner ? req1_addr : req0_addr;
      e_read  = 1; e_busy = 1;
      m_act = 1; m_acc = 0; m_t = 0;
    end
    #1;
    chk("flash_read", flash_read, e_read);
    chk("flash_address", flash_address, e_addr);
    chk("busy", busy, e_busy);
    chk("owner", owner, e_owner);
    chk("req0_done", req0_done, e_done0);
    chk("req1_done", req1_done, e_done1);
    chk("req0_err", req0_err, e_err0);
    chk("req1_err", req1_err, e_err1);
    chk("req0_data", req0_data, e_data0);
    chk("req1_data", req1_data, e_data1);
    if (busy && !p_busy) begin
      g_cyc  = cyc;
      rd_cnt = 0;
    end
    p_busy = busy;
    if (flash_read) rd_cnt++;
    if (req0_done || req1_done) begin
      n_done++;
      d_cyc  = cyc;
      d_port = req1_done;
      d_err  = req0_err | req1_err;
      dq_port.push_back(int'(req1_done));
      dq_cyc.push_back(cyc);
    end
  end

  // flash slave: edges counted from the grant edge (E0 = flash_read rise)
  int nw = 0, de = 0, le = 0, g = 1000;
  logic [DW-1:0] word = '0;
  bit rd_prev = 0;

  always @(negedge clk) begin
    if (flash_read && !rd_prev) g = 0;
    else g++;
    rd_prev = flash_read;
    flash_waitrequest   = (g + 1 <= nw);
    flash_readdatavalid = (g + 1 == de) || (g + 1 == le);
    flash_readdata      = flash_readdatavalid ? word : 16'hBAD0;
  end

  task automatic one(input bit p, input logic [AW-1:0] a, input int w,
                     input int d, input int late, input logic [DW-1:0] wd,
                     input int xlat, input int xrd, input bit xerr,
                     input logic [DW-1:0] xdata);
    int n0;
    int k;
    @(negedge clk);
    nw = w; de = d; le = late; word = wd;
    if (p) begin req1 = 1; req1_addr = a; end
    else   begin req0 = 1; req0_addr = a; end
    n0 = n_done;
    k = 0;
    while (n_done == n0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    req0 = 0; req1 = 0;
    chk("done_seen", n_done != n0, 1);
    if (n_done != n0) begin
      chk("latency", d_cyc - g_cyc, xlat);
      chk("read_cycles", rd_cnt, xrd);
      chk("done_port", d_port, p);
      chk("done_err", d_err, xerr);
      chk("done_data", p ? req1_data : req0_data, xdata);
    end
    repeat (4) @(negedge clk);
    chk("single_done", n_done - n0, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic rr(input int n);
    int k;
    @(negedge clk);
    nw = 0; de = 2; le = 0; word = 16'h3C3C;
    dq_port.delete();
    dq_cyc.delete();
    req0 = 1; req0_addr = 23'h000111;
    req1 = 1; req1_addr = 23'h000222;
    k = 0;
    while (dq_port.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    req0 = 0; req1 = 0;
    chk("rr_count", dq_port.size(), n);
    for (int i = 0; i < dq_port.size(); i++)
      chk("rr_port", dq_port[i], i % 2);
    if (dq_cyc.size() == n && n > 1)
      chk("rr_span", dq_cyc[n-1] - dq_cyc[0], 4 * (n - 1));
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_read", flash_read, 0);
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("init_busy", busy, 0);
    chk("init_addr", flash_address, 0);
    chk("init_data0", req0_data, 0);

    one(0, 23'h000010, 0, 2, 0, 16'h5555, 2, 1, 0, 16'h5555);
    one(0, 23'h000123, 10, 12, 0, 16'h1234, 12, 11, 0, 16'h1234);
    one(1, 23'h07ABCD, 2, 6, 0, 16'hA5A5, 6, 3, 0, 16'hA5A5);
    one(1, 23'h000040, 0, 0, 18, 16'hDEAD, 16, 1, 1, 16'hA5A5);
    chk("late_data_ignored", req1_data, 16'hA5A5);
    one(0, 23'h000055, 30, 0, 0, 16'h0000, 16, 16, 1, 16'h1234);
    one(1, 23'h000099, 0, 16, 0, 16'h0F0F, 16, 1, 0, 16'h0F0F);

    do_reset();
    rr(4);

    @(negedge clk);
    nw = 0; de = 5; le = 0; word = 16'h7777;
    req0 = 1; req0_addr = 23'h000ABC;
    n0 = n_done;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_read", flash_read, 0);
    reset = 1; req0 = 0;
    @(negedge clk);
    reset = 0;
    chk("mrst_busy", busy, 0);
    chk("mrst_addr", flash_address, 0);
    chk("mrst_data0", req0_data, 0);
    repeat (6) @(negedge clk);
    chk("mrst_no_done", n_done - n0, 0);

    rr(1);
    one(0, 23'h000020, 0, 2, 0, 16'hBEEF, 2, 1, 0, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck want=finish");
    $fatal(1, "watchdog");
  end

endmodule
